// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid: elastic inter-stage register with valid/ready handshake,
// flush, bubble (NOP) insertion and an optional two-entry skid buffer.
module pipeline_stage_skid #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter bit                SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rdy_q, rdy_d;
  logic              accept;
  logic              transfer;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VALUE;
  assign occupancy = state_q;
  assign transfer  = out_valid & out_ready;
  assign accept    = in_valid & in_ready;

  // rdy_q is low through reset and the release edge; in skid mode it also
  // tracks "not full" one register stage ahead, so in_ready has no input path.
  assign rdy_d = (state_d != TWO);

  generate
    if (SKID) begin : g_skid
      assign in_ready = rdy_q;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
          EMPTY: begin
            if (accept) begin
              state_d = ONE;
              main_d  = in_data;
            end
          end
          ONE: begin
            case ({accept, transfer})
              2'b11: main_d = in_data;
              2'b10: begin
                state_d = TWO;
                skid_d  = in_data;
              end
              2'b01: state_d = EMPTY;
              default: ;
            endcase
          end
          TWO: begin
            if (transfer) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
        // A flush still lets the cycle's handshakes complete; it only drops entries.
        if (flush) begin
          state_d = EMPTY;
        end
      end
    end else begin : g_noskid
      assign in_ready = rdy_q & (~out_valid | out_ready);

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end else if (transfer) begin
          state_d = EMPTY;
        end
        if (flush) begin
          state_d = EMPTY;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: three configurations checked against a
// bounded-FIFO reference model under directed and random traffic.
module tb_pipeline_stage_skid;

  localparam logic [63:0] NOP2 = 64'h0100_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  in_valid, out_ready, flush;
  logic [63:0] din [3];

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [31:0] od0, od1;
  logic [63:0] od2;
  logic [1:0]  occ0, occ1, occ2;
  logic [31:0] d0, d1;
  logic [63:0] d2;

  assign d0 = din[0][31:0];
  assign d1 = din[1][31:0];
  assign d2 = din[2];

  always #5 clk = ~clk;

  pipeline_stage_skid #(.DATA_W(32), .SKID(1'b1)) u0 (
    .clk(clk), .reset_n(reset_n), .flush(flush[0]), .in_valid(in_valid[0]),
    .in_ready(rdy0), .in_data(d0), .out_valid(ov0), .out_ready(out_ready[0]),
    .out_data(od0), .occupancy(occ0));

  pipeline_stage_skid #(.DATA_W(32), .SKID(1'b0)) u1 (
    .clk(clk), .reset_n(reset_n), .flush(flush[1]), .in_valid(in_valid[1]),
    .in_ready(rdy1), .in_data(d1), .out_valid(ov1), .out_ready(out_ready[1]),
    .out_data(od1), .occupancy(occ1));

  pipeline_stage_skid #(.DATA_W(64), .NOP_VALUE(NOP2), .SKID(1'b1)) u2 (
    .clk(clk), .reset_n(reset_n), .flush(flush[2]), .in_valid(in_valid[2]),
    .in_ready(rdy2), .in_data(d2), .out_valid(ov2), .out_ready(out_ready[2]),
    .out_data(od2), .occupancy(occ2));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a FIFO of capacity 2 (skid) or 1 (no skid) per instance.
  logic [63:0] fifo [3][2];
  int          cnt  [3];
  bit          up;
  bit          skidp [3];
  logic [63:0] nopv  [3];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit exp_ready(input int i);
    if (!up) return 1'b0;
    if (skidp[i]) return (cnt[i] < 2);
    return (cnt[i] == 0) || out_ready[i];
  endfunction

  task automatic drive(input int i, input bit v, input logic [63:0] d, input bit r, input bit f);
    in_valid[i]  = v;
    din[i]       = d;
    out_ready[i] = r;
    flush[i]     = f;
  endtask

  task automatic drive_all(input bit v, input logic [63:0] d, input bit r, input bit f);
    for (int i = 0; i < 3; i++) drive(i, v, d, r, f);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    logic        a_val, a_rdy, acc, xf, rdy_e;
    logic [63:0] a_data, e_data;
    logic [1:0]  a_occ;
    #1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin a_val = ov0; a_rdy = rdy0; a_data = {32'd0, od0}; a_occ = occ0; end
        1:       begin a_val = ov1; a_rdy = rdy1; a_data = {32'd0, od1}; a_occ = occ1; end
        default: begin a_val = ov2; a_rdy = rdy2; a_data = od2;          a_occ = occ2; end
      endcase
      e_data = (cnt[i] > 0) ? fifo[i][0] : nopv[i];
      check_val($sformatf("u%0d in_ready", i), {63'd0, a_rdy}, {63'd0, exp_ready(i)});
      check_val($sformatf("u%0d out_valid", i), {63'd0, a_val}, {63'd0, cnt[i] > 0});
      check_val($sformatf("u%0d out_data", i), a_data, e_data);
      check_val($sformatf("u%0d occupancy", i), {62'd0, a_occ}, 64'(cnt[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        cnt[i] = 0;
        continue;
      end
      rdy_e = exp_ready(i);
      acc   = in_valid[i] && rdy_e;
      xf    = (cnt[i] > 0) && out_ready[i];
      if (xf) $display("u%0d xfer data=%h", i, fifo[i][0]);
      if (flush[i]) begin
        cnt[i] = 0;
      end else begin
        if (xf) begin
          fifo[i][0] = fifo[i][1];
          cnt[i]--;
        end
        if (acc && cnt[i] < 2) begin
          fifo[i][cnt[i]] = (i < 2) ? {32'd0, din[i][31:0]} : din[i];
          cnt[i]++;
        end
      end
    end
    up = reset_n;
    @(negedge clk);
  endtask

  initial begin
    skidp = '{1'b1, 1'b0, 1'b1};
    nopv  = '{64'd0, 64'd0, NOP2};
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    up      = 1'b0;
    reset_n = 1'b0;
    drive_all(1'b0, 64'd0, 1'b0, 1'b0);

    // Reset, then release: in_ready rises one edge after release.
    @(negedge clk);
    cycle();
    cycle();
    reset_n = 1'b1;
    $display("reset released");
    cycle();
    cycle();

    // Streaming 1..8 with out_ready held high.
    for (int k = 1; k <= 8; k++) begin
      drive_all(1'b1, 64'(k), 1'b1, 1'b0);
      cycle();
    end
    drive_all(1'b0, 64'd0, 1'b1, 1'b0);
    cycle();
    cycle();

    // Skid fill: A, B under stall, C offered while full, then drain.
    drive_all(1'b1, 64'hA, 1'b0, 1'b0); cycle();
    drive_all(1'b1, 64'hB, 1'b0, 1'b0); cycle();
    drive_all(1'b1, 64'hC, 1'b0, 1'b0); cycle();
    check_val("skid full occ", {62'd0, occ0}, 64'd2);
    drive_all(1'b0, 64'd0, 1'b1, 1'b0); cycle();
    cycle();
    cycle();

    // Flush while full and while E is offered.
    drive_all(1'b1, 64'hC, 1'b0, 1'b0); cycle();
    drive_all(1'b1, 64'hD, 1'b0, 1'b0); cycle();
    drive_all(1'b1, 64'hE, 1'b0, 1'b1); cycle();
    check_val("flush occ", {62'd0, occ0}, 64'd0);
    check_val("flush nop u2", od2, NOP2);
    drive_all(1'b0, 64'd0, 1'b1, 1'b0); cycle();
    cycle();

    // No-skid backpressure then simultaneous transfer and accept.
    drive_all(1'b1, 64'h11, 1'b0, 1'b0); cycle();
    drive_all(1'b1, 64'h22, 1'b0, 1'b0); cycle();
    drive_all(1'b1, 64'h33, 1'b1, 1'b0); cycle();
    drive_all(1'b0, 64'd0, 1'b1, 1'b0); cycle();
    cycle();
    cycle();

    // Asynchronous reset with two entries held, mid-cycle.
    drive_all(1'b1, 64'h44, 1'b0, 1'b0); cycle();
    drive_all(1'b1, 64'h55, 1'b0, 1'b0); cycle();
    #2 reset_n = 1'b0;
    #1;
    check_val("async rst occ", {62'd0, occ0}, 64'd0);
    check_val("async rst valid", {63'd0, ov0}, 64'd0);
    check_val("async rst data", {32'd0, od0}, 64'd0);
    check_val("async rst ready", {63'd0, rdy0}, 64'd0);
    check_val("async rst nop u2", od2, NOP2);
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    up = 1'b0;
    $display("async reset asserted");
    @(negedge clk);
    cycle();
    reset_n = 1'b1;
    cycle();
    cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        drive(i, ($urandom_range(0, 9) < 7), {$urandom, $urandom},
              ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
      end
      cycle();
    end
    drive_all(1'b0, 64'd0, 1'b1, 1'b0);
    cycle();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
